// File: rtl/bsg_permute_sequencer.sv
// Streaming permute sequencer: applies one table pattern per accepted beat, cycling through a programmed count.
// Optional accepted-beat counter output beats_o is enabled by defining BSG_PERMUTE_SEQ_PERF_EN.
module bsg_permute_sequencer #(
   parameter  int els_p       = 4,
   parameter  int width_p     = 8,
   parameter  int depth_p     = 4,
   localparam int lg_els_lp   = $clog2(els_p),
   localparam int lg_depth_lp = $clog2(depth_p),
   localparam int pat_w_lp    = els_p * lg_els_lp
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       cfg_v_i,
   input  logic [lg_depth_lp-1:0]     cfg_addr_i,
   input  logic [pat_w_lp-1:0]        cfg_pattern_i,
   output logic                       cfg_ready_o,
   input  logic                       start_i,
   input  logic [lg_depth_lp:0]       num_i,
   input  logic                       stop_i,
   input  logic                       v_i,
   input  logic [els_p*width_p-1:0]   data_i,
   output logic                       ready_o,
   output logic                       v_o,
   output logic [els_p*width_p-1:0]   data_o,
   input  logic                       ready_i,
   output logic                       busy_o,
   output logic [lg_depth_lp-1:0]     pattern_idx_o
`ifdef BSG_PERMUTE_SEQ_PERF_EN
   ,
   output logic [31:0]                beats_o
`endif
);

   typedef enum logic [1:0] {
      e_idle,
      e_run,
      e_drain
   } state_e;

   state_e                      r_state;
   logic [pat_w_lp-1:0]         r_table [depth_p];
   logic [lg_depth_lp-1:0]      r_ptr;
   logic [lg_depth_lp:0]        r_len;
   logic                        r_v;
   logic [els_p*width_p-1:0]    r_data;

   logic                        w_accept;
   logic                        w_consume;
   logic                        w_ptr_last;
   logic [lg_depth_lp:0]        w_len_clamped;
   logic [pat_w_lp-1:0]         w_sel;
   logic [width_p-1:0]          w_elems [els_p];
   logic [els_p*width_p-1:0]    w_perm;

   assign ready_o       = (r_state == e_run) & (~r_v | ready_i);
   assign cfg_ready_o   = (r_state == e_idle);
   assign busy_o        = (r_state != e_idle);
   assign v_o           = r_v;
   assign data_o        = r_data;
   assign pattern_idx_o = r_ptr;

   assign w_accept   = v_i & ready_o;
   assign w_consume  = r_v & ready_i;
   assign w_ptr_last = ({1'b0, r_ptr} == (r_len - (lg_depth_lp+1)'(1)));

   // A zero or oversized count means "use the whole table".
   assign w_len_clamped = ((num_i == '0) || (num_i > (lg_depth_lp+1)'(depth_p)))
                          ? (lg_depth_lp+1)'(depth_p) : num_i;

   always_comb begin
      w_sel  = r_table[r_ptr];
      w_perm = '0;
      for (int i = 0; i < els_p; i++) begin
         w_elems[i] = data_i[i*width_p +: width_p];
      end
      for (int i = 0; i < els_p; i++) begin
         w_perm[i*width_p +: width_p] = w_elems[w_sel[i*lg_els_lp +: lg_els_lp]];
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= e_idle;
         r_ptr   <= '0;
         r_len   <= (lg_depth_lp+1)'(depth_p);
         r_v     <= 1'b0;
         r_data  <= '0;
         for (int d = 0; d < depth_p; d++) begin
            for (int i = 0; i < els_p; i++) begin
               r_table[d][i*lg_els_lp +: lg_els_lp] <= lg_els_lp'(i);
            end
         end
      end else begin
         case (r_state)
            e_idle: begin
               if (cfg_v_i) begin
                  r_table[cfg_addr_i] <= cfg_pattern_i;
               end
               if (start_i) begin
                  r_len   <= w_len_clamped;
                  r_ptr   <= '0;
                  r_state <= e_run;
               end
            end
            e_run: begin
               if (stop_i) begin
                  r_state <= e_drain;
               end
            end
            e_drain: begin
               if (!r_v || ready_i) begin
                  r_state <= e_idle;
               end
            end
            default: r_state <= e_idle;
         endcase

         // Accepts only happen in RUN, so this never collides with the start reload of r_ptr.
         if (w_accept) begin
            r_data <= w_perm;
            r_v    <= 1'b1;
            r_ptr  <= w_ptr_last ? '0 : r_ptr + lg_depth_lp'(1);
         end else if (w_consume) begin
            r_v <= 1'b0;
         end
      end
   end

`ifdef BSG_PERMUTE_SEQ_PERF_EN
   logic [31:0] r_beats;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_beats <= '0;
      end else if ((r_state == e_idle) && start_i) begin
         r_beats <= '0;
      end else if (w_accept) begin
         r_beats <= r_beats + 32'd1;
      end
   end

   assign beats_o = r_beats;
`endif

endmodule

// File: tb/tb_bsg_permute_sequencer.sv
// Self-checking bench for bsg_permute_sequencer: directed literal scenarios plus randomized traffic
// compared every cycle against a behavioural model (beat count modulo run length, per-entry select lists).
module tb_bsg_permute_sequencer;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;

   logic        clk_i;
   logic        reset_n_i;
   logic        cfg_v_i;
   logic [1:0]  cfg_addr_i;
   logic [7:0]  cfg_pattern_i;
   logic        cfg_ready_o;
   logic        start_i;
   logic [2:0]  num_i;
   logic        stop_i;
   logic        v_i;
   logic [31:0] data_i;
   logic        ready_o;
   logic        v_o;
   logic [31:0] data_o;
   logic        ready_i;
   logic        busy_o;
   logic [1:0]  pattern_idx_o;
`ifdef BSG_PERMUTE_SEQ_PERF_EN
   logic [31:0] beats_o;
`endif

   int errors = 0;
   int checks = 0;
   logic checkEn = 1'b0;

   bsg_permute_sequencer #(.els_p(4), .width_p(8), .depth_p(4)) dut (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .cfg_v_i       (cfg_v_i),
      .cfg_addr_i    (cfg_addr_i),
      .cfg_pattern_i (cfg_pattern_i),
      .cfg_ready_o   (cfg_ready_o),
      .start_i       (start_i),
      .num_i         (num_i),
      .stop_i        (stop_i),
      .v_i           (v_i),
      .data_i        (data_i),
      .ready_o       (ready_o),
      .v_o           (v_o),
      .data_o        (data_o),
      .ready_i       (ready_i),
      .busy_o        (busy_o),
      .pattern_idx_o (pattern_idx_o)
`ifdef BSG_PERMUTE_SEQ_PERF_EN
      ,
      .beats_o       (beats_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Behavioural model: pattern index is simply the number of beats accepted since start, modulo the run length.
   int         mState;
   int         mLen;
   int         mBeats;
   logic       mV;
   logic [31:0] mData;
   logic [1:0] mSel [4][4];

   function automatic int expIdx();
      return mBeats % mLen;
   endfunction

   function automatic logic expReady();
      return reset_n_i && (mState == M_RUN) && (!mV || ready_i);
   endfunction

   function automatic logic [31:0] permute(input logic [31:0] d, input int e);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = d[8*int'(mSel[e][i]) +: 8];
      end
      return r;
   endfunction

   always @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mState <= M_IDLE;
         mLen   <= 4;
         mBeats <= 0;
         mV     <= 1'b0;
         mData  <= '0;
         for (int e = 0; e < 4; e++) begin
            for (int j = 0; j < 4; j++) begin
               mSel[e][j] <= 2'(j);
            end
         end
      end else begin
         if (mState == M_IDLE) begin
            if (cfg_v_i) begin
               for (int j = 0; j < 4; j++) begin
                  mSel[cfg_addr_i][j] <= cfg_pattern_i[2*j +: 2];
               end
            end
            if (start_i) begin
               mState <= M_RUN;
               mLen   <= ((num_i == 3'd0) || (num_i > 3'd4)) ? 4 : int'(num_i);
               mBeats <= 0;
            end
         end else if (mState == M_RUN) begin
            if (stop_i) mState <= M_DRAIN;
         end else begin
            if (!mV || ready_i) mState <= M_IDLE;
         end
         if (v_i && expReady()) begin
            mData  <= permute(data_i, expIdx());
            mV     <= 1'b1;
            mBeats <= mBeats + 1;
         end else if (mV && ready_i) begin
            mV <= 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actVal, input logic [31:0] expVal);
      checks++;
      if (actVal !== expVal) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actVal, expVal, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (checkEn) begin
         checkOutput("cmp_v_o", 32'(v_o), 32'(mV));
         checkOutput("cmp_ready_o", 32'(ready_o), 32'(expReady()));
         checkOutput("cmp_busy_o", 32'(busy_o), 32'(mState != M_IDLE));
         checkOutput("cmp_cfg_ready_o", 32'(cfg_ready_o), 32'(mState == M_IDLE));
         checkOutput("cmp_pattern_idx_o", 32'(pattern_idx_o), 32'(expIdx()));
         if (mV) checkOutput("cmp_data_o", data_o, mData);
      end
   end

   task automatic applyStimulus(input logic cv, input logic [1:0] ca, input logic [7:0] cp,
                                input logic st, input logic [2:0] nm, input logic sp,
                                input logic vi, input logic [31:0] di, input logic ri);
      cfg_v_i       = cv;
      cfg_addr_i    = ca;
      cfg_pattern_i = cp;
      start_i       = st;
      num_i         = nm;
      stop_i        = sp;
      v_i           = vi;
      data_i        = di;
      ready_i       = ri;
      @(posedge clk_i);
      #1;
   endtask

   task automatic goIdle();
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      reset_n_i = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkEn = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("rst_v_o", 32'(v_o), 0);
      checkOutput("rst_data_o", data_o, 0);
      checkOutput("rst_busy_o", 32'(busy_o), 0);
      checkOutput("rst_cfg_ready_o", 32'(cfg_ready_o), 1);
      checkOutput("rst_ready_o", 32'(ready_o), 0);
      checkOutput("rst_idx", 32'(pattern_idx_o), 0);
      reset_n_i = 1'b1;

      // Get a beat in flight, then reset asynchronously.
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h44332211, 0);
      checkOutput("inflight_v_o", 32'(v_o), 1);
      reset_n_i = 1'b0;
      #1;
      checkOutput("async_rst_v_o", 32'(v_o), 0);
      checkOutput("async_rst_data_o", data_o, 0);
      checkOutput("async_rst_busy_o", 32'(busy_o), 0);
      checkOutput("async_rst_cfg_ready_o", 32'(cfg_ready_o), 1);
      checkOutput("async_rst_ready_o", 32'(ready_o), 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      reset_n_i = 1'b1;
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h44332211, 1);
      checkOutput("identity_data", data_o, 32'h44332211);
      goIdle();

      // Reverse pattern written in the same cycle as start.
      applyStimulus(1, 0, 8'h1B, 1, 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h44332211, 1);
      checkOutput("reverse_data1", data_o, 32'h11223344);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hDDCCBBAA, 1);
      checkOutput("reverse_v2", 32'(v_o), 1);
      checkOutput("reverse_data2", data_o, 32'hAABBCCDD);
      goIdle();

      // Cycle reverse / rotate.
      applyStimulus(1, 1, 8'h39, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 0, 8'h1B, 1, 2, 0, 0, 0, 1);
      checkOutput("cycle_idx0", 32'(pattern_idx_o), 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h44332211, 1);
      checkOutput("cycle_data1", data_o, 32'h11223344);
      checkOutput("cycle_idx1", 32'(pattern_idx_o), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h44332211, 1);
      checkOutput("cycle_data2", data_o, 32'h11443322);
      checkOutput("cycle_idx2", 32'(pattern_idx_o), 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h44332211, 1);
      checkOutput("cycle_data3", data_o, 32'h11223344);
      checkOutput("cycle_idx3", 32'(pattern_idx_o), 1);

      // Backpressure holds data; release accepts in the same cycle.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h55667788, 0);
         checkOutput("bp_ready_o", 32'(ready_o), 0);
         checkOutput("bp_data_o", data_o, 32'h11223344);
      end
      v_i     = 1'b1;
      data_i  = 32'h44332211;
      ready_i = 1'b1;
      #1;
      checkOutput("bp_release_ready_o", 32'(ready_o), 1);
      @(posedge clk_i);
      #1;
      checkOutput("bp_release_data", data_o, 32'h11443322);

      // Stop while stalled, then drain.
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h01020304, 0);
      checkOutput("drain_ready_o", 32'(ready_o), 0);
      checkOutput("drain_busy_o", 32'(busy_o), 1);
      checkOutput("drain_v_o", 32'(v_o), 1);
      checkOutput("drain_data_o", data_o, 32'h11443322);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("drain_cfg_ready_o", 32'(cfg_ready_o), 1);
      checkOutput("drain_done_busy_o", 32'(busy_o), 0);

      // Config writes during RUN are ignored.
      applyStimulus(0, 0, 0, 1, 2, 0, 0, 0, 1);
      applyStimulus(1, 0, 8'hE4, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h44332211, 1);
      checkOutput("ignored_cfg_data", data_o, 32'h11223344);
      goIdle();

      // Randomized traffic; the compare process does the checking.
      for (int n = 0; n < 1500; n++) begin
         if (n == 700) begin
            reset_n_i = 1'b0;
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
            reset_n_i = 1'b1;
         end
         applyStimulus(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom),
                       1'($urandom_range(0, 7) == 0), 3'($urandom),
                       1'($urandom_range(0, 15) == 0),
                       1'($urandom_range(0, 3) != 0), $urandom,
                       1'($urandom_range(0, 3) != 0));
      end

      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
